vga_pattern_generator: RTL and testbench
========================================

Name: vga_pattern_generator

Overview:
- Parametrised successor of the fixed three-stripe picture generator: owns its own VGA h/v timing counters and drives sync plus RGB.
- Resolution, porches, sync polarity, colour depth and stripe count are parameters.
- Four run-time modes: horizontal stripes, vertical bars, checkerboard, solid. Colours come from a packed palette input.
- Mode and palette changes are applied only at frame start, so a frame never tears. Sits between the board clock/reset and the VGA pins; also feeds pixel coordinates to downstream overlay logic.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
COLOR_W, 4, bits per colour channel
STRIPES, 3, palette entries / stripe count (>=2)
CELL_LOG2, 5, checkerboard cell size = 2^CELL_LOG2 pixels

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
mode_in  in  2  requested mode: 0 h-stripes, 1 v-bars, 2 checker, 3 solid
mode_load  in  1  one-cycle strobe; captures mode_in into pending register
palette_in  in  STRIPES*3*COLOR_W  entry k at bits [(k+1)*3*COLOR_W-1 : k*3*COLOR_W], packed {R,G,B}
vga_h_sync  out  1  horizontal sync
vga_v_sync  out  1  vertical sync
vga_R / vga_G / vga_B  out  COLOR_W each  colour channels
in_display_area  out  1  high when the current output pixel is visible
pix_x  out  10  x of the current output pixel (valid when in_display_area)
pix_y  out  10  y of the current output pixel
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters: H_TOTAL = sum of the H_* parameters (800 default); V_TOTAL = sum of the V_* parameters (525 default).
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps 0 after V_TOTAL-1.
- Sync:
  - hsync active while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync active for the same window on v_cnt using the V_* parameters.
  - Active level = SYNC_POL.
- Visible region: h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- Latency: all outputs are registered. Outputs at cycle t reflect the counter state at t-1, so syncs, colour, in_display_area, pix_x/pix_y and frame_start stay mutually aligned.
- Reset (async assert, sync release):
  - h_cnt = 0, v_cnt = 0.
  - Syncs at their inactive level (~SYNC_POL); RGB = 0; in_display_area = 0; pix_x = pix_y = 0; frame_start = 0.
  - active_mode = 0, pending_mode = 0; active palette = 0.
  - Reset mid-frame restarts at (0,0). The first output frame after release is complete.
- Mode and palette update:
  - mode_load captures mode_in into pending_mode; the last strobe before frame start wins.
  - When the counters are at (0,0), active_mode <= pending_mode and the active palette <= palette_in in the same cycle; that pixel already uses the new values.
  - A mode_load in the same cycle as (0,0) applies at the next frame.
  - palette_in changes mid-frame have no visible effect.
- Colour selection, visible pixels only (blanking outputs RGB = 0):
  - Mode 0: entry floor(y*STRIPES/V_VISIBLE). Implement with a boundary counter or multiplier; the result must be exact.
  - Mode 1: entry floor(x*STRIPES/H_VISIBLE).
  - Mode 2: entry 0 if bit 0 of ((x>>CELL_LOG2) XOR (y>>CELL_LOG2)) is 0, else entry 1.
  - Mode 3: entry 0.
- frame_start: high for exactly one cycle per frame, coincident with output pixel (0,0).

Test Plan:
- Reset low for 5 cycles mid-line, then release → RGB = 0, syncs high for defaults; first output pixel (0,0) appears 1 cycle after release with frame_start = 1.
- Free-run defaults for 2 frames:
  - hsync low exactly at h = 656..751 (96 clocks) every 800 clocks.
  - vsync low for lines 490..491.
  - frame_start period 420000 clocks.
- Mode 0, palette {entry0 = F00, entry1 = FFF, entry2 = 00F} → rows 0..159 = F00, 160..319 = FFF, 320..479 = 00F; RGB = 0 for x >= 640 and y >= 480.
- mode_in = 1 strobed mid-frame → current frame still shows h-stripes; next frame has x 0..213 = entry0, 214..426 = entry1, 427..639 = entry2.
- Mode 2, CELL_LOG2 = 5 → (0,0) = entry0, (32,0) = entry1, (32,32) = entry0, (31,31) = entry0; palette_in changed mid-frame → colours unchanged until the next frame_start.
- Reassert reset during visible area of mode 2 → outputs go to reset values immediately (async); after release the mode is 0 and counters restart from (0,0).

Source files
------------

// File: rtl/vga_pattern_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_pattern_generator
// Purpose  : Self-timed VGA test-pattern source. Owns the h/v timing
//            counters, drives sync and RGB, and exports pixel coordinates.
//            Four run-time patterns (h-stripes, v-bars, checkerboard, solid)
//            with mode and palette latched only at frame start.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int COLOR_W   = 4,
  parameter int STRIPES   = 3,
  parameter int CELL_LOG2 = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode_in,
  input  logic                           mode_load,
  input  logic [STRIPES*3*COLOR_W-1:0]   palette_in,
  output logic                           vga_h_sync,
  output logic                           vga_v_sync,
  output logic [COLOR_W-1:0]             vga_R,
  output logic [COLOR_W-1:0]             vga_G,
  output logic [COLOR_W-1:0]             vga_B,
  output logic                           in_display_area,
  output logic [9:0]                     pix_x,
  output logic [9:0]                     pix_y,
  output logic                           frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = 3 * COLOR_W;
  localparam int PAL_W   = STRIPES * PW;
  localparam int IW      = $clog2(STRIPES);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  // Timing counters
  logic [HW-1:0]    h_cnt_q, h_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;

  // Mode / palette staging
  logic [1:0]       pending_mode_q, pending_mode_d;
  logic [1:0]       active_mode_q, active_mode_d;
  logic [PAL_W-1:0] active_pal_q, active_pal_d;

  // Registered outputs
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic             de_q, de_d;
  logic             frame_start_q, frame_start_d;
  logic [PW-1:0]    rgb_q, rgb_d;
  logic [9:0]       pix_x_q, pix_x_d;
  logic [9:0]       pix_y_q, pix_y_d;

  // Combinational helpers
  logic [31:0]      h_pos, v_pos;
  logic             at_origin;
  logic             visible;
  logic [1:0]       eff_mode;
  logic [PAL_W-1:0] eff_pal;
  logic [IW-1:0]    entry;

  assign h_pos     = 32'(h_cnt_q);
  assign v_pos     = 32'(v_cnt_q);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign visible   = (h_pos < H_VISIBLE) && (v_pos < V_VISIBLE);

  // Exact floor(pos*STRIPES/span): count the band boundaries k*span/STRIPES
  // that pos has reached, compared in the scaled domain to avoid division.
  function automatic logic [IW-1:0] band_index(input logic [31:0] pos,
                                               input int          span);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 1; k < STRIPES; k++) begin
      if (pos * 32'(STRIPES) >= 32'(k) * 32'(span)) begin
        idx = idx + IW'(1);
      end
    end
    return idx;
  endfunction

  // Free-running raster counters: h wraps every line, v advances on h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end
  end

  // Mode/palette staging: at the frame origin the pending values take effect
  // for that very pixel; a strobe on the origin cycle waits a full frame.
  always_comb begin
    pending_mode_d = mode_load ? mode_in : pending_mode_q;
    eff_mode       = at_origin ? pending_mode_q : active_mode_q;
    eff_pal        = at_origin ? palette_in : active_pal_q;
    active_mode_d  = eff_mode;
    active_pal_d   = eff_pal;
  end

  // Palette entry selection for the current pattern
  always_comb begin
    entry = '0;
    unique case (eff_mode)
      2'd0:    entry = band_index(v_pos, V_VISIBLE);
      2'd1:    entry = band_index(h_pos, H_VISIBLE);
      2'd2:    entry = IW'(h_pos[CELL_LOG2] ^ v_pos[CELL_LOG2]);
      default: entry = '0;
    endcase
  end

  // Next-state of the output register stage, all derived from one counter state
  always_comb begin
    h_sync_d      = ((h_pos >= H_VISIBLE + H_FRONT) &&
                     (h_pos <  H_VISIBLE + H_FRONT + H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
    v_sync_d      = ((v_pos >= V_VISIBLE + V_FRONT) &&
                     (v_pos <  V_VISIBLE + V_FRONT + V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
    de_d          = visible;
    rgb_d         = visible ? eff_pal[entry*PW +: PW] : '0;
    pix_x_d       = 10'(h_cnt_q);
    pix_y_d       = 10'(v_cnt_q);
    frame_start_d = at_origin;
  end

  // State and output registers; async assert, release restarts at (0,0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      pending_mode_q <= '0;
      active_mode_q  <= '0;
      active_pal_q   <= '0;
      h_sync_q       <= ~SYNC_ACT;
      v_sync_q       <= ~SYNC_ACT;
      de_q           <= 1'b0;
      rgb_q          <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      pending_mode_q <= pending_mode_d;
      active_mode_q  <= active_mode_d;
      active_pal_q   <= active_pal_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      de_q           <= de_d;
      rgb_q          <= rgb_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign vga_h_sync      = h_sync_q;
  assign vga_v_sync      = v_sync_q;
  assign vga_R           = rgb_q[PW-1 -: COLOR_W];
  assign vga_G           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_B           = rgb_q[COLOR_W-1 -: COLOR_W];
  assign in_display_area = de_q;
  assign pix_x           = pix_x_q;
  assign pix_y           = pix_y_q;
  assign frame_start     = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_generator
// Purpose  : Self-checking bench for vga_pattern_generator using a reduced
//            raster (80 x 31 total, 64 x 24 visible) so frames are short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_generator;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 24, VF = 2, VS = 2, VB = 3;
  localparam int CW = 4, NS = 3, CL = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PW = 3 * CW;
  localparam int PALW = NS * PW;

  localparam logic [PALW-1:0] PAL_A = 36'h00F_FFF_F00;
  localparam logic [PALW-1:0] PAL_B = 36'h0A5_5A0_123;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      mode_in = 2'd0;
  logic            mode_load = 1'b0;
  logic [PALW-1:0] palette_in = PAL_A;
  logic            vga_h_sync, vga_v_sync;
  logic [CW-1:0]   vga_R, vga_G, vga_B;
  logic            in_display_area;
  logic [9:0]      pix_x, pix_y;
  logic            frame_start;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_pattern_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .COLOR_W(CW), .STRIPES(NS), .CELL_LOG2(CL)
  ) dut (
    .clk(clk), .reset(reset),
    .mode_in(mode_in), .mode_load(mode_load), .palette_in(palette_in),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .in_display_area(in_display_area),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct {
    int          mode;
    int          x;
    int          y;
    logic [11:0] rgb;
  } vec_t;

  obs_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t get_obs(input bit mask);
    obs_t o;
    o.hs  = vga_h_sync;
    o.vs  = vga_v_sync;
    o.de  = in_display_area;
    o.x   = (mask && !in_display_area) ? 10'd0 : pix_x;
    o.y   = (mask && !in_display_area) ? 10'd0 : pix_y;
    o.fs  = frame_start;
    o.rgb = {vga_R, vga_G, vga_B};
    return o;
  endfunction

  // Reference pixel straight from the raster definition
  function automatic obs_t model_px(input int h, input int v, input int mode,
                                    input logic [PALW-1:0] pal);
    obs_t o;
    int   idx;
    bit   vis;
    vis  = (h < HV) && (v < VV);
    o.hs = !((h >= HV + HF) && (h < HV + HF + HS));
    o.vs = !((v >= VV + VF) && (v < VV + VF + VS));
    o.de = vis;
    o.x  = vis ? 10'(h) : 10'd0;
    o.y  = vis ? 10'(v) : 10'd0;
    o.fs = (h == 0) && (v == 0);
    case (mode)
      0:       idx = (v * NS) / VV;
      1:       idx = (h * NS) / HV;
      2:       idx = ((h >> CL) ^ (v >> CL)) & 1;
      default: idx = 0;
    endcase
    o.rgb = vis ? pal[idx*PW +: PW] : 12'h000;
    return o;
  endfunction

  // Scoreboard producer: expected output for the pixel the DUT is latching now
  int              m_h = 0;
  int              m_v = 0;
  logic [1:0]      m_pend = 2'd0;
  logic [1:0]      m_mode = 2'd0;
  logic [PALW-1:0] m_pal = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_h    <= 0;
      m_v    <= 0;
      m_pend <= 2'd0;
      m_mode <= 2'd0;
      m_pal  <= '0;
      sbq.delete();
    end else begin
      if (m_h == 0 && m_v == 0) begin
        sbq.push_back(model_px(m_h, m_v, int'(m_pend), palette_in));
        m_mode <= m_pend;
        m_pal  <= palette_in;
      end else begin
        sbq.push_back(model_px(m_h, m_v, int'(m_mode), m_pal));
      end
      if (mode_load) m_pend <= mode_in;
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  // Scoreboard consumer: compare every registered output cycle
  always @(posedge clk) begin : b_sb
    obs_t e;
    #1;
    if (reset && sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("scoreboard", 64'(get_obs(1'b1)), 64'(e));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mode(input int m);
    mode_in   = 2'(m);
    mode_load = 1'b1;
    step();
    mode_load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    step();
    n = 1;
    while (!frame_start && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("wait_frame_start", 64'(frame_start), 64'd1);
  endtask

  task automatic wait_pixel(input int x, input int y);
    int n;
    n = 0;
    while (!(in_display_area && pix_x == 10'(x) && pix_y == 10'(y)) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk($sformatf("reach_pixel_%0d_%0d", x, y), 64'(in_display_area && pix_x == 10'(x) && pix_y == 10'(y)), 64'd1);
  endtask

  task automatic chk_rgb(input string name, input logic [11:0] exp);
    chk(name, 64'({vga_R, vga_G, vga_B}), 64'(exp));
  endtask

  task automatic chk_origin(input string name);
    chk({name, "_fs"},  64'(frame_start), 64'd1);
    chk({name, "_de"},  64'(in_display_area), 64'd1);
    chk({name, "_xy"},  64'({pix_x, pix_y}), 64'd0);
  endtask

  vec_t tbl[19];

  initial begin : b_main
    int cur_mode;
    int hs_low, vs_low, fs_n, first_hs, first_vs;

    tbl[0]  = '{0,  5,  0, 12'hF00};
    tbl[1]  = '{0,  5,  7, 12'hF00};
    tbl[2]  = '{0,  5,  8, 12'hFFF};
    tbl[3]  = '{0, 63, 15, 12'hFFF};
    tbl[4]  = '{0,  0, 16, 12'h00F};
    tbl[5]  = '{0, 40, 23, 12'h00F};
    tbl[6]  = '{1,  0,  1, 12'hF00};
    tbl[7]  = '{1, 21,  1, 12'hF00};
    tbl[8]  = '{1, 22,  1, 12'hFFF};
    tbl[9]  = '{1, 42,  1, 12'hFFF};
    tbl[10] = '{1, 43,  1, 12'h00F};
    tbl[11] = '{1, 63,  2, 12'h00F};
    tbl[12] = '{2,  0,  0, 12'hF00};
    tbl[13] = '{2,  8,  0, 12'hFFF};
    tbl[14] = '{2,  7,  7, 12'hF00};
    tbl[15] = '{2,  8,  8, 12'hF00};
    tbl[16] = '{2, 16,  9, 12'hFFF};
    tbl[17] = '{3, 10,  3, 12'hF00};
    tbl[18] = '{3, 50, 20, 12'hF00};

    // Power-on reset, then first pixel one cycle after release
    repeat (3) step();
    chk("por_reset_values", 64'(get_obs(1'b0)), 64'({1'b1, 1'b1, 34'd0}));
    reset = 1'b1;
    step();
    chk_origin("first_px");

    // Mid-line reset for 5 cycles: async reset values, restart at (0,0)
    repeat (30) step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midline_reset_values", 64'(get_obs(1'b0)), 64'({1'b1, 1'b1, 34'd0}));
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_origin("restart_px");
    chk_rgb("restart_rgb", 12'hF00);

    // Two free-running frames: sync windows and frame period
    wait_frame();
    for (int f = 0; f < 2; f++) begin
      hs_low = 0; vs_low = 0; fs_n = 0; first_hs = -1; first_vs = -1;
      for (int i = 0; i < FRAME; i++) begin
        if (!vga_h_sync) begin
          hs_low++;
          if (first_hs < 0) first_hs = i;
        end
        if (!vga_v_sync) begin
          vs_low++;
          if (first_vs < 0) first_vs = i;
        end
        if (frame_start) fs_n++;
        step();
      end
      chk("hsync_low_cycles", 64'(hs_low), 64'(VT * HS));
      chk("hsync_first_pos",  64'(first_hs), 64'(HV + HF));
      chk("vsync_low_cycles", 64'(vs_low), 64'(VS * HT));
      chk("vsync_first_pos",  64'(first_vs), 64'((VV + VF) * HT));
      chk("frame_start_count", 64'(fs_n), 64'd1);
      chk("frame_period", 64'(frame_start), 64'd1);
    end

    // Table-driven colour points per mode
    cur_mode = -1;
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].mode != cur_mode) begin
        load_mode(tbl[i].mode);
        wait_frame();
        cur_mode = tbl[i].mode;
      end
      wait_pixel(tbl[i].x, tbl[i].y);
      chk_rgb($sformatf("tbl%0d_rgb", i), tbl[i].rgb);
    end

    // Mid-frame mode change is deferred to the next frame
    load_mode(0);
    wait_frame();
    wait_pixel(10, 4);
    load_mode(1);
    wait_pixel(30, 20);
    chk_rgb("midframe_mode_still_hstripe", 12'h00F);
    wait_frame();
    wait_pixel(30, 2);
    chk_rgb("next_frame_vbar", 12'hFFF);

    // Strobe landing exactly on the origin cycle waits one more frame
    wait_frame();
    repeat (FRAME - 1) step();
    load_mode(3);
    chk("origin_strobe_fs", 64'(frame_start), 64'd1);
    wait_pixel(63, 5);
    chk_rgb("origin_strobe_deferred", 12'h00F);
    wait_frame();
    wait_pixel(63, 5);
    chk_rgb("origin_strobe_applied", 12'hF00);

    // Palette change mid-frame only shows after the next frame start
    load_mode(2);
    wait_frame();
    wait_pixel(0, 2);
    palette_in = PAL_B;
    wait_pixel(8, 16);
    chk_rgb("palette_midframe_hold", 12'hFFF);
    wait_frame();
    wait_pixel(8, 16);
    chk_rgb("palette_next_frame", 12'h5A0);

    // Reset in the visible area of mode 2: async clear, mode back to 0
    wait_pixel(20, 10);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("visible_reset_values", 64'(get_obs(1'b0)), 64'({1'b1, 1'b1, 34'd0}));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_origin("post_reset_px");
    wait_pixel(8, 10);
    chk_rgb("post_reset_mode0", 12'h5A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : b_watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
